parity_serializer: RTL and testbench
====================================

// Module: parity_serializer
// PURPOSE
//  Parallel-to-serial transmitter. Accepts a DATA_W-bit word on a valid/ready handshake.
//  Shifts the word out LSB-first on one serial line, then appends a parity bit.
//  Running parity is built from the team's gate-level xor_gate (z = xy' + x'y) in a feedback loop.
//  Sits upstream of the serial link/checker stage that consumes sout.
// PARAMETERS
//  DATA_W  8  word width in bits (>= 2)
//  ODD     0  0 = even parity (total ones incl. parity even), 1 = odd parity
// PORTS
//  clock        in   1       single clock, all state updates on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  din          in   DATA_W  parallel word
//  din_valid    in   1       din holds a word to send
//  din_ready    out  1       block can accept din this cycle
//  sout         out  1       serial data, idle-high
//  sout_valid   out  1       sout carries a frame bit (data or parity)
//  frame_start  out  1       high while sout = bit 0 of a word
//  frame_end    out  1       high while sout = parity bit
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, sout=1, sout_valid=0, frame_start=0, frame_end=0,
//    shift reg=0, bit count=0, parity acc=ODD. Applies immediately, even mid-frame; that frame is dropped.
//  - All outputs except din_ready are registered. din_ready is combinational: 1 in IDLE or PARITY, else 0.
//  - Accept = din_valid & din_ready at a rising edge T0. din is sampled at T0 only.
//  - FSM: IDLE -> SHIFT on accept. SHIFT (cnt=0..DATA_W-1) -> PARITY after cnt=DATA_W-1.
//    PARITY -> SHIFT on accept (back-to-back), else -> IDLE.
//  - Edge T0: sout<=din[0], sout_valid<=1, frame_start<=1, cnt<=0, acc<=ODD^din[0], shreg<=din>>1.
//  - Edges T1..T(DATA_W-1): sout<=next shreg bit, frame_start<=0, acc<=acc^bit (via xor_gate), cnt++.
//  - Edge T(DATA_W): sout<=acc (final parity), frame_end<=1, state=PARITY.
//  - Leaving PARITY to IDLE: sout<=1, sout_valid<=0, frame_end<=0.
//  - Latency: first bit visible the cycle after accept. Frame = DATA_W+1 cycles.
//    Back-to-back words leave no idle gap.
//  - din_valid is ignored while in SHIFT; no data loss, since ready=0 there.
//  - Parity: XOR of all DATA_W data bits, XOR ODD. Counter width = $clog2(DATA_W+1).
// CONFIGURATION
//  - `PARITY_SER_STOP_BIT_EN defined: adds state STOP after PARITY. In STOP: sout=1, sout_valid=1,
//    frame_end moves to STOP (0 during parity bit). din_ready=1 in IDLE or STOP (not PARITY).
//    Frame = DATA_W+2 cycles.
//  - Undefined: no STOP state, behaviour exactly as above.
// TESTING
//  1. Reset: reset_n=0 asynchronously mid-frame (word 8'hFF, bit 3) -> same cycle sout=1,
//     sout_valid=0, din_ready=1; no further bits.
//  2. DATA_W=8, ODD=0, din=8'hA5 accepted at T0 -> sout T1..T8 = 1,0,1,0,0,1,0,1.
//     Parity=0 at T9 with frame_end=1; frame_start=1 only for bit 0.
//  3. din=8'h07, ODD=0 -> parity bit 1. ODD=1, din=8'h00 -> parity bit 1.
//     ODD=1, din=8'h03 -> parity bit 1.
//  4. Back-to-back: din_valid held high with 8'h01 then 8'h80 -> 18 consecutive sout_valid cycles.
//     Second frame_start follows frame_end directly; din_ready low for 8 cycles per word.
//  5. Handshake hold: din_valid=1 while in SHIFT with changing din -> din ignored until PARITY.
//     The word present when ready=1 is the one sent.
//  6. With `PARITY_SER_STOP_BIT_EN, din=8'hA5 -> 8 data bits, parity 0, then stop bit 1
//     with frame_end=1. Next accept only in STOP/IDLE.

Source files
------------

// File: rtl/parity_serializer.sv
// parity_serializer: parallel-to-serial transmitter. Takes a DATA_W-bit word on a
// valid/ready handshake, sends it LSB-first and then appends a parity bit.
// Optional build macro PARITY_SER_STOP_BIT_EN appends a stop bit (sout=1) after the parity
// bit. In that build frame_end marks the stop bit, and din_ready is high in IDLE/STOP.
module parity_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              frame_start,
  output logic              frame_end
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
`ifdef PARITY_SER_STOP_BIT_EN
  localparam logic [1:0] StStop   = 2'd3;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic              sout_q, sout_d;
  logic              sout_valid_q, sout_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              accept;
  logic              next_bit;
  logic              acc_xor;

  // Ready is combinational: high while idle or while the last bit of a frame is on the line
`ifdef PARITY_SER_STOP_BIT_EN
  assign din_ready = (state_q == StIdle) | (state_q == StStop);
`else
  assign din_ready = (state_q == StIdle) | (state_q == StParity);
`endif

  assign accept   = din_valid & din_ready;
  assign next_bit = shreg_q[0];
  // Gate-level XOR (z = xy' + x'y) closing the running-parity feedback loop
  assign acc_xor  = (acc_q & ~next_bit) | (~acc_q & next_bit);

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    sout_d        = sout_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = frame_start_q;
    frame_end_d   = frame_end_q;
    case (state_q)
      StShift: begin
        frame_start_d = 1'b0;
        if (cnt_q == LastCnt) begin
          // acc already holds ODD ^ all data bits
          sout_d  = acc_q;
          state_d = StParity;
`ifdef PARITY_SER_STOP_BIT_EN
          frame_end_d = 1'b0;
`else
          frame_end_d = 1'b1;
`endif
        end else begin
          sout_d  = next_bit;
          acc_d   = acc_xor;
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
`ifdef PARITY_SER_STOP_BIT_EN
      StParity: begin
        sout_d      = 1'b1;
        frame_end_d = 1'b1;
        state_d     = StStop;
      end
`endif
      default: begin
        // Idle or final frame bit: either load the next word back-to-back or go quiet
        if (accept) begin
          state_d       = StShift;
          sout_d        = din[0];
          sout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
          frame_end_d   = 1'b0;
          cnt_d         = '0;
          acc_d         = ODD ^ din[0];
          shreg_d       = din >> 1;
        end else begin
          state_d       = StIdle;
          sout_d        = 1'b1;
          sout_valid_d  = 1'b0;
          frame_start_d = 1'b0;
          frame_end_d   = 1'b0;
        end
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      acc_q         <= ODD;
      sout_q        <= 1'b1;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: even and odd parity instances share one stimulus stream and
// are compared cycle by cycle against a frame-level model (queue of expected line symbols).
module tb_parity_serializer;

  localparam int unsigned W = 8;
`ifdef PARITY_SER_STOP_BIT_EN
  localparam bit StopEn = 1'b1;
`else
  localparam bit StopEn = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy_e, sout_e, sv_e, fs_e, fe_e;
  logic         rdy_o, sout_o, sv_o, fs_o, fe_o;

  always #5 clock = ~clock;

  parity_serializer #(.DATA_W(W), .ODD(1'b0)) u_dut_even (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (rdy_e),
    .sout       (sout_e),
    .sout_valid (sv_e),
    .frame_start(fs_e),
    .frame_end  (fe_e)
  );

  parity_serializer #(.DATA_W(W), .ODD(1'b1)) u_dut_odd (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (rdy_o),
    .sout       (sout_o),
    .sout_valid (sv_o),
    .frame_start(fs_o),
    .frame_end  (fe_o)
  );

  // kind: 0 = data bit, 1 = parity (val = XOR of the word's data bits), 2 = stop bit
  typedef struct packed {
    logic [1:0] kind;
    logic       val;
    logic       first;
  } item_t;

  item_t exp_q[$];
  item_t cur;
  bit    cur_busy;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return exp_q.size() == 0;
  endfunction

  function automatic logic exp_sout(input bit odd);
    if (!cur_busy) return 1'b1;
    case (cur.kind)
      2'd0:    return cur.val;
      2'd1:    return cur.val ^ odd;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_end();
    if (!cur_busy) return 1'b0;
    return (cur.kind == 2'd2) || (cur.kind == 2'd1 && !StopEn);
  endfunction

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) exp_q.push_back('{kind: 2'd0, val: w[i], first: (i == 0)});
    exp_q.push_back('{kind: 2'd1, val: ^w, first: 1'b0});
    if (StopEn) exp_q.push_back('{kind: 2'd2, val: 1'b1, first: 1'b0});
  endtask

  task automatic check_ready();
    check_eq("ready_even", rdy_e, model_ready());
    check_eq("ready_odd", rdy_o, model_ready());
  endtask

  task automatic check_outputs();
    check_eq("sout_even", sout_e, exp_sout(1'b0));
    check_eq("sout_odd", sout_o, exp_sout(1'b1));
    check_eq("valid_even", sv_e, cur_busy);
    check_eq("valid_odd", sv_o, cur_busy);
    check_eq("start_even", fs_e, cur_busy && cur.kind == 2'd0 && cur.first);
    check_eq("start_odd", fs_o, cur_busy && cur.kind == 2'd0 && cur.first);
    check_eq("end_even", fe_e, exp_end());
    check_eq("end_odd", fe_o, exp_end());
  endtask

  // One clock: inputs already driven at the preceding falling edge
  task automatic step();
    check_ready();
    @(posedge clock);
    if (din_valid && model_ready()) push_frame(din);
    if (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      cur_busy = 1'b1;
    end else begin
      cur_busy = 1'b0;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b0;
      din       = W'($urandom);
      step();
    end
  endtask

  // Hold valid high; din is junk until the model says ready, so a word seen in SHIFT
  // must never be the one sent.
  task automatic send_word(input logic [W-1:0] w);
    bit sent = 1'b0;
    while (!sent) begin
      din_valid = 1'b1;
      sent      = model_ready();
      din       = sent ? w : W'($urandom);
      step();
    end
  endtask

  logic [W-1:0] directed [6];

  initial begin
    directed[0] = 8'hA5;
    directed[1] = 8'h07;
    directed[2] = 8'h00;
    directed[3] = 8'h03;
    directed[4] = 8'h01;
    directed[5] = 8'h80;
    reset_n   = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    cur_busy  = 1'b0;
    #12;
    check_ready();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);

    // Single frames with gaps, then 01/80 back-to-back
    for (int i = 0; i < 4; i++) begin
      send_word(directed[i]);
      idle(W + 3);
    end
    send_word(directed[4]);
    send_word(directed[5]);
    idle(W + 3);

    // Asynchronous reset while bit 3 of 8'hFF is on the line
    send_word(8'hFF);
    idle(3);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    cur_busy = 1'b0;
    #1;
    check_ready();
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    idle(W + 4);

    // Random words, random gaps, frequent back-to-back runs
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send_word(W'($urandom));
    end
    idle(W + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
